// File: rtl/tx_byte_fifo_if.sv
// Byte-stream handshake bundle between a producer, the TX FIFO and the UART transmitter.
// The slave side is the FIFO; the master side is whatever drives and drains it.
interface tx_byte_fifo_if #(
    parameter int Width = 8
);
    logic [Width-1:0] InData;
    logic             InValid;
    logic             InReady;
    logic [Width-1:0] OutData;
    logic             OutValid;
    logic             OutReady;

    modport master (
        output InData,
        output InValid,
        output OutReady,
        input  InReady,
        input  OutData,
        input  OutValid
    );

    modport slave (
        input  InData,
        input  InValid,
        input  OutReady,
        output InReady,
        output OutData,
        output OutValid
    );
endinterface

// File: rtl/tx_byte_fifo.sv
// First-word-fall-through byte FIFO that buffers bytes ahead of a UART transmitter.
// There is no bypass path in either direction: a byte becomes visible one cycle after it is pushed.
module tx_byte_fifo #(
    parameter  int Depth      = 8,
    parameter  int Width      = 8,
    localparam int CountWidth = $clog2(Depth) + 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Flush,
    tx_byte_fifo_if.slave         bus,
    output logic [CountWidth-1:0] Count
);

    localparam int AddrWidth = $clog2(Depth);

    logic [Width-1:0]     mem [Depth];
    logic [AddrWidth-1:0] readPtr;
    logic [AddrWidth-1:0] writePtr;
    logic                 push;
    logic                 pop;

    assign bus.InReady  = (Count != CountWidth'(Depth));
    assign bus.OutValid = (Count != '0);
    assign bus.OutData  = mem[readPtr];

    assign push = bus.InValid  && bus.InReady  && !Flush && !Reset;
    assign pop  = bus.OutValid && bus.OutReady && !Flush && !Reset;

    // Pointers wrap naturally because Depth is a power of two; Count carries one extra bit to tell full from empty.
    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            readPtr  <= '0;
            writePtr <= '0;
            Count    <= '0;
        end else begin
            if (push) begin
                writePtr <= writePtr + AddrWidth'(1);
            end
            if (pop) begin
                readPtr <= readPtr + AddrWidth'(1);
            end
            if (push && !pop) begin
                Count <= Count + CountWidth'(1);
            end else if (pop && !push) begin
                Count <= Count - CountWidth'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[writePtr] <= bus.InData;
        end
    end

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Scoreboard bench for tx_byte_fifo: the driver queues every byte it expects to be accepted,
// and a negedge monitor checks status outputs and pops/compares whenever the head is consumed.
module tb_tx_byte_fifo;

    localparam int Depth = 8;
    localparam int Width = 8;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Flush;
    logic [3:0] Count;

    tx_byte_fifo_if #(.Width(Width)) bus ();

    tx_byte_fifo #(.Depth(Depth), .Width(Width)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Flush (Flush),
        .bus   (bus),
        .Count (Count)
    );

    always #5 Clock = ~Clock;

    logic [Width-1:0] expQ [$];
    int               total = 0;
    int               bad   = 0;
    bit               checking = 1'b0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs mid-cycle while the inputs for the coming edge are stable.
    task automatic checkOutput();
        int unsigned sz;
        sz = expQ.size();
        checkValue("Count", {28'd0, Count}, sz);
        checkValue("InReady", {31'd0, bus.InReady}, (sz != Depth) ? 32'd1 : 32'd0);
        checkValue("OutValid", {31'd0, bus.OutValid}, (sz != 0) ? 32'd1 : 32'd0);
        if (sz != 0) begin
            checkValue("OutData", {24'd0, bus.OutData}, {24'd0, expQ[0]});
            if (bus.OutReady && !Flush && !Reset) begin
                void'(expQ.pop_front());
            end
        end
    endtask

    always @(negedge Clock) begin
        if (checking) begin
            checkOutput();
        end
    end

    // Drives one cycle of inputs and updates the scoreboard after the edge.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [Width-1:0] d, input logic ordy);
        bit willPush;
        Reset        = rst;
        Flush        = fl;
        bus.InValid  = iv;
        bus.InData   = d;
        bus.OutReady = ordy;
        willPush = iv && (expQ.size() != Depth) && !fl && !rst;
        @(posedge Clock);
        #1;
        if (rst || fl) begin
            expQ.delete();
        end else if (willPush) begin
            expQ.push_back(d);
        end
    endtask

    task automatic checkCount(input string name, input int exp);
        checkValue(name, {28'd0, Count}, exp);
    endtask

    initial begin
        Reset        = 1'b1;
        Flush        = 1'b0;
        bus.InValid  = 1'b0;
        bus.InData   = '0;
        bus.OutReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        expQ.delete();
        checking = 1'b1;
        checkCount("reset count", 0);
        checkValue("reset InReady", {31'd0, bus.InReady}, 32'd1);
        checkValue("reset OutValid", {31'd0, bus.OutValid}, 32'd0);

        // Fill to full with the consumer stalled, then offer one more byte that must be refused.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
            checkCount("fill count", i);
        end
        checkValue("full InReady", {31'd0, bus.InReady}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        checkCount("full ignore", 8);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkCount("drain count", 0);
        checkValue("drain OutValid", {31'd0, bus.OutValid}, 32'd0);

        // Full with a pop and a push offered together: only the pop happens.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1);
        checkCount("full-hold pop", 7);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
        checkCount("full-hold push", 8);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkCount("full-hold drain", 0);

        // Streaming through the pointer wrap twice.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
            checkCount("stream count", 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkCount("stream drain", 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        end
        checkCount("pre-flush count", 5);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1);
        checkCount("flush count", 0);
        checkValue("flush OutValid", {31'd0, bus.OutValid}, 32'd0);
        checkValue("flush InReady", {31'd0, bus.InReady}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        checkValue("post-flush OutData", {24'd0, bus.OutData}, 32'h55);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        checkCount("mid-reset count", 0);
        checkValue("mid-reset OutValid", {31'd0, bus.OutValid}, 32'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
        checkValue("post-reset OutData", {24'd0, bus.OutData}, 32'h66);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkCount("final count", 0);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_byte_fifo.md
TX_BYTE_FIFO -- requirements
Module: tx_byte_fifo

Interface
REQ-001 Parameter: Depth, default 8, number of byte entries; SHALL be a power of two >= 2.
REQ-002 Parameter: Width, default 8, bits per entry.
REQ-003 Localparam: CountWidth = log2(Depth)+1, width of Count.
REQ-004 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Flush  input  1  synchronous discard of all stored entries.
REQ-007 InData  input  Width  byte offered by the producer.
REQ-008 InValid  input  1  producer has a byte on InData.
REQ-009 InReady  output  1  FIFO can accept a byte this cycle.
REQ-010 OutData  output  Width  head-of-queue byte, intended for the UART transmitter's data input.
REQ-011 OutValid  output  1  OutData holds a valid entry, intended for the transmitter's valid input.
REQ-012 OutReady  input  1  consumer takes the head entry this cycle, driven by the transmitter's ready output.
REQ-013 Count  output  CountWidth  number of stored entries, 0..Depth.

Function
REQ-014 Push SHALL occur when InValid && InReady && !Flush && !Reset, writing InData at the write pointer.
REQ-015 Pop SHALL occur when OutValid && OutReady && !Flush && !Reset, advancing the read pointer.
REQ-016 InReady SHALL be combinational: (Count != Depth); no dependence on OutReady (no full-bypass).
REQ-017 OutValid SHALL be combinational: (Count != 0); no dependence on InValid (no empty-bypass).
REQ-018 OutData SHALL equal the entry at the read pointer (first-word-fall-through); value is don't-care while OutValid = 0.
REQ-019 Latency: a byte pushed in cycle N SHALL appear on OutData with OutValid = 1 in cycle N+1 when the FIFO was empty.
REQ-020 Count next: +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle or on neither.
REQ-021 Simultaneous push and pop with 0 < Count < Depth SHALL both take effect; order preserved.
REQ-022 Full (Count = Depth): InReady = 0; InValid SHALL be ignored even if a pop occurs in the same cycle.
REQ-023 Empty (Count = 0): OutValid = 0; OutReady SHALL be ignored; no pointer change.
REQ-024 Read and write pointers SHALL be log2(Depth) bits and wrap from Depth-1 to 0 with no lost or duplicated entry.
REQ-025 Bytes SHALL emerge in exact push order; no entry SHALL be modified after it is written.
REQ-026 Flush = 1 SHALL set both pointers and Count to 0 at the next edge; any push or pop in that cycle SHALL be discarded.
REQ-027 Inputs held stable across cycles while InReady = 0 SHALL NOT be pushed more than once after InReady rises.

Reset
REQ-028 Reset SHALL take priority over Flush, push and pop.
REQ-029 After a Reset edge: pointers = 0, Count = 0, OutValid = 0, InReady = 1.
REQ-030 Reset asserted mid-stream SHALL discard all stored entries; storage array contents need not be cleared.
REQ-031 Outputs during the cycle Reset is high SHALL reflect pre-reset state; post-reset values apply from the next cycle.

Verification
REQ-032 Fill: Depth=8, push 0x01..0x08, OutReady=0 -> Count 1..8, InReady=0 after 8th push, OutData=0x01 throughout.
REQ-033 Drain: from full, OutReady=1 for 8 cycles -> OutData 0x01..0x08 in order, then OutValid=0, Count=0.
REQ-034 Full-hold: full, InValid=1 with InData=0xAA and OutReady=1 -> one pop, 0xAA not pushed that cycle, Count=7; 0xAA pushed next cycle, Count back to 8.
REQ-035 Streaming/wrap: InValid=1 and OutReady=1 continuously for 20 bytes 0x10..0x23 starting empty -> Count stays at 1 after the first cycle, output sequence is 0x10..0x23 in order, pointers wrap twice.
REQ-036 Flush: Count=5, assert Flush with InValid=1 and OutReady=1 -> next cycle Count=0, OutValid=0, InReady=1; the next push of 0x55 appears as OutData=0x55.
REQ-037 Reset mid-operation: Count=3, Reset=1 for 1 cycle with InValid=1 -> Count=0, OutValid=0; no byte from the reset cycle is ever output.
